// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the ALU share arbiter: operation codes,
// NZCV flag bit positions and the arbiter FSM state type.
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu.sv
// 32-bit ALU: ADD, SUB, AND, OR with NZCV flags.
// Carry is bit 32 of the 33-bit unsigned sum or difference; for SUB that bit
// is set when a borrow occurs.
module alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  alu_control,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   logic [32:0] sum;
   logic [32:0] diff;
   logic        carry;
   logic        overflow;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // Select the result for the operation and derive the four flags from it
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (alu_control)
         ALU_ADD: begin
            result   = sum[31:0];
            carry    = sum[32];
            overflow = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         ALU_SUB: begin
            result   = diff[31:0];
            carry    = diff[32];
            overflow = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         ALU_AND: result = a & b;
         default: result = a | b;
      endcase
      flags         = '0;
      flags[FLAG_N] = result[31];
      flags[FLAG_Z] = (result == 32'd0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = overflow;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
// One operation at a time: IDLE (grant) -> EXEC (compute) -> RESP (hold
// response until accepted). Optionally updates the architectural NZCV register.
//
// Handshakes: a request transfers on a clock edge where ReqValid[i] and
// ReqReady[i] are both 1; a response transfers on an edge where RspValid and
// RspReady are both 1. ReqReady is only ever asserted in IDLE and is one-hot;
// Rsp* outputs stay stable while RspValid is 1 and RspReady is 0.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int REQ_W   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     ReqValid,
   output logic [NUM_REQ-1:0]     ReqReady,
   input  logic [32*NUM_REQ-1:0]  ReqSrcA,
   input  logic [32*NUM_REQ-1:0]  ReqSrcB,
   input  logic [2*NUM_REQ-1:0]   ReqALUControl,
   input  logic [NUM_REQ-1:0]     ReqSetFlags,
   output logic                   RspValid,
   output logic [REQ_W-1:0]       RspId,
   output logic [31:0]            RspResult,
   output logic [3:0]             RspFlag,
   input  logic                   RspReady,
   output logic [3:0]             FlagReg,
   output logic                   Busy,
   output logic [1:0]             dbg_state,
   output logic [REQ_W-1:0]       dbg_rr_ptr
);

   state_t             state;
   state_t             state_next;
   logic [REQ_W-1:0]   rr_ptr;

   logic [NUM_REQ-1:0] pick_onehot;
   logic               pick_any;
   logic [REQ_W-1:0]   pick_id;
   logic [REQ_W-1:0]   pick_id_next;
   logic [31:0]        pick_a;
   logic [31:0]        pick_b;
   logic [1:0]         pick_op;
   logic               pick_sf;

   logic [31:0]        op_a;
   logic [31:0]        op_b;
   logic [1:0]         op_ctl;
   logic               op_sf;
   logic [REQ_W-1:0]   op_id;

   logic [31:0]        alu_result;
   logic [3:0]         alu_flags;

   // Round-robin picker: first valid requester at or above rr_ptr, with wrap
   always_comb begin
      int idx;
      idx          = 0;
      pick_onehot  = '0;
      pick_any     = 1'b0;
      pick_id      = '0;
      pick_a       = '0;
      pick_b       = '0;
      pick_op      = ALU_ADD;
      pick_sf      = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!pick_any && ReqValid[idx]) begin
            pick_any         = 1'b1;
            pick_onehot[idx] = 1'b1;
            pick_id          = REQ_W'(idx);
            pick_a           = ReqSrcA[32*idx +: 32];
            pick_b           = ReqSrcB[32*idx +: 32];
            pick_op          = ReqALUControl[2*idx +: 2];
            pick_sf          = ReqSetFlags[idx];
         end
      end
      pick_id_next = (int'(pick_id) + 1 >= NUM_REQ) ? '0 : pick_id + REQ_W'(1);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_any) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (RspReady) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: grant only while idle, plus status/debug views
   always_comb begin
      ReqReady   = (state == IDLE) ? pick_onehot : '0;
      Busy       = (state != IDLE);
      dbg_state  = state;
      dbg_rr_ptr = rr_ptr;
   end

   // Datapath: latch operands on grant, register the response in EXEC,
   // drop RspValid once the response is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_ctl    <= ALU_ADD;
         op_sf     <= 1'b0;
         op_id     <= '0;
         RspValid  <= 1'b0;
         RspId     <= '0;
         RspResult <= '0;
         RspFlag   <= '0;
         FlagReg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  op_a   <= pick_a;
                  op_b   <= pick_b;
                  op_ctl <= pick_op;
                  op_sf  <= pick_sf;
                  op_id  <= pick_id;
                  rr_ptr <= pick_id_next;
               end
            end
            EXEC: begin
               RspValid  <= 1'b1;
               RspId     <= op_id;
               RspResult <= alu_result;
               RspFlag   <= alu_flags;
               if (op_sf) FlagReg <= alu_flags;
            end
            RESP: begin
               if (RspReady) RspValid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   alu u_alu (
      .a           (op_a),
      .b           (op_b),
      .alu_control (op_ctl),
      .result      (alu_result),
      .flags       (alu_flags)
   );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level reference model and a response queue.
module tb_alu_share_arbiter;

   localparam int NUM_REQ = 2;
   localparam int REQ_W   = 2;
   localparam int W       = 38;   // {id[1:0], result[31:0], nzcv[3:0]}

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic        sf;
   } op_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] src_a = '0;
   logic [32*NUM_REQ-1:0] src_b = '0;
   logic [2*NUM_REQ-1:0]  alu_ctl = '0;
   logic [NUM_REQ-1:0]    set_flags = '0;
   logic                  rsp_valid;
   logic [REQ_W-1:0]      rsp_id;
   logic [31:0]           rsp_result;
   logic [3:0]            rsp_flag;
   logic                  rsp_ready = 1'b0;
   logic [3:0]            flag_reg;
   logic                  busy;
   logic [1:0]            dbg_state;
   logic [REQ_W-1:0]      dbg_rr;

   // reference model state
   int            m_phase = 0;          // 0 waiting, 1 computing, 2 presenting
   int            m_rr = 0;
   logic [3:0]    m_flag = '0;
   logic [3:0]    m_pend_flags = '0;
   logic          m_pend_sf = 1'b0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  cur = '0;
   bit            have_cur = 1'b0;
   bit [NUM_REQ-1:0] taken = '0;
   op_t           req_q[NUM_REQ][$];
   logic [1:0]    dut_ids[$];
   op_t           drv_op;
   op_t           mdl_op;
   logic [35:0]   mdl_rf;
   int            mdl_g;

   int            rdy_mode = 0;         // 0 always ready, 1 random, 2 hold low 5 cycles
   bit            gaps = 1'b0;
   int            hold_cnt = 0;
   int            total = 0;
   int            bad = 0;

   alu_share_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) dut (
      .clk           (clk),
      .reset         (rst),
      .ReqValid      (req_valid),
      .ReqReady      (req_ready),
      .ReqSrcA       (src_a),
      .ReqSrcB       (src_b),
      .ReqALUControl (alu_ctl),
      .ReqSetFlags   (set_flags),
      .RspValid      (rsp_valid),
      .RspId         (rsp_id),
      .RspResult     (rsp_result),
      .RspFlag       (rsp_flag),
      .RspReady      (rsp_ready),
      .FlagReg       (flag_reg),
      .Busy          (busy),
      .dbg_state     (dbg_state),
      .dbg_rr_ptr    (dbg_rr)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // first valid requester at or after the round-robin position, -1 if none
   function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
      for (int k = 0; k < NUM_REQ; k++)
         if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int g);
      logic [NUM_REQ-1:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // arithmetic reference: {result, N, Z, C, V} from integer arithmetic
   function automatic logic [35:0] ref_alu(input op_t o);
      logic [63:0] ua, ub, uw;
      longint      sa, sb, sw;
      logic [31:0] r;
      logic        c, v;
      ua = {32'd0, o.a};
      ub = {32'd0, o.b};
      sa = $signed(o.a);
      sb = $signed(o.b);
      c  = 1'b0;
      v  = 1'b0;
      case (o.op)
         2'b00: begin
            uw = ua + ub; r = uw[31:0];
            c  = (uw != {32'd0, r});
            sw = sa + sb; v = (sw != longint'($signed(r)));
         end
         2'b01: begin
            uw = ua - ub; r = uw[31:0];
            c  = (ua < ub);
            sw = sa - sb; v = (sw != longint'($signed(r)));
         end
         2'b10:   r = o.a & o.b;
         default: r = o.a | o.b;
      endcase
      return {r, r[31], (r == 32'd0), c, v};
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   function automatic bit all_done();
      for (int i = 0; i < NUM_REQ; i++)
         if (req_q[i].size() != 0) return 1'b0;
      return (req_valid == '0) && (m_phase == 0) && (exp_q.size() == 0);
   endfunction

   // reference model: decides grants, predicts responses, tracks NZCV
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase  = 0;
         m_rr     = 0;
         m_flag   = '0;
         exp_q.delete();
         have_cur = 1'b0;
         taken    = '0;
      end else begin
         case (m_phase)
            0: begin
               mdl_g = pick(req_valid, m_rr);
               if (mdl_g >= 0 && req_q[mdl_g].size() > 0) begin
                  mdl_op       = req_q[mdl_g].pop_front();
                  mdl_rf       = ref_alu(mdl_op);
                  m_pend_flags = mdl_rf[3:0];
                  m_pend_sf    = mdl_op.sf;
                  exp_q.push_back({2'(mdl_g), mdl_rf});
                  m_rr         = (mdl_g + 1) % NUM_REQ;
                  taken[mdl_g] = 1'b1;
                  m_phase      = 1;
               end
            end
            1: begin
               if (m_pend_sf) m_flag = m_pend_flags;
               m_phase = 2;
            end
            default: begin
               if (rsp_ready) begin
                  m_phase  = 0;
                  have_cur = 1'b0;
               end
            end
         endcase
      end
   end

   // monitor (scoreboard side) then request/response drivers, on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         req_valid = '0;
         rsp_ready = 1'b0;
         hold_cnt  = 0;
      end else begin
         chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
         chk("busy", 64'(busy), 64'(m_phase != 0));
         chk("flag_reg", 64'(flag_reg), 64'(m_flag));
         if (m_phase == 2) begin
            if (!have_cur) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rsp_unexpected: got response id %0d, none expected", rsp_id);
               end else begin
                  cur      = exp_q.pop_front();
                  have_cur = 1'b1;
                  dut_ids.push_back(rsp_id);
               end
            end
            if (have_cur) begin
               chk("rsp_id", 64'(rsp_id), 64'(cur[37:36]));
               chk("rsp_result", 64'(rsp_result), 64'(cur[35:4]));
               chk("rsp_flag", 64'(rsp_flag), 64'(cur[3:0]));
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (taken[i]) begin
               req_valid[i] = 1'b0;
               taken[i]     = 1'b0;
            end
            if (!req_valid[i] && req_q[i].size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
               drv_op                 = req_q[i][0];
               req_valid[i]           = 1'b1;
               src_a[32*i +: 32]      = drv_op.a;
               src_b[32*i +: 32]      = drv_op.b;
               alu_ctl[2*i +: 2]      = drv_op.op;
               set_flags[i]           = drv_op.sf;
            end
         end
         case (rdy_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = 1'($urandom_range(0, 1));
            default: begin
               if (m_phase == 2) begin
                  hold_cnt++;
                  rsp_ready = (hold_cnt > 5);
               end else begin
                  hold_cnt  = 0;
                  rsp_ready = 1'b0;
               end
            end
         endcase
         #1;
         chk("req_ready", 64'(req_ready),
             64'((m_phase == 0) ? onehot(pick(req_valid, m_rr)) : '0));
      end
   end

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (n < budget && !all_done()) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: waited %0d cycles, phase %0d", n, m_phase);
      end
      @(negedge clk);
      #3;
   endtask

   task automatic wait_phase(input int ph, input string name);
      int n;
      n = 0;
      while (m_phase != ph && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (m_phase != ph) begin
         total++;
         bad++;
         $display("FAIL %s: phase %0d not reached, at %0d", name, ph, m_phase);
      end
   endtask

   // directed scenarios, then random traffic
   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_id", 64'(rsp_id), 64'(0));
      chk("reset_rsp_result", 64'(rsp_result), 64'(0));
      chk("reset_rsp_flag", 64'(rsp_flag), 64'(0));
      chk("reset_flag_reg", 64'(flag_reg), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_state", 64'(dbg_state), 64'(0));
      chk("reset_rr", 64'(dbg_rr), 64'(0));
      rst = 1'b0;

      // ADD with carry-out to zero, flags written
      rdy_mode = 0;
      req_q[0].push_back('{a: 32'hFFFF_FFFF, b: 32'h0000_0001, op: 2'b00, sf: 1'b1});
      wait_drain(200);
      chk("t1_result", 64'(rsp_result), 64'(32'h0000_0000));
      chk("t1_flag", 64'(rsp_flag), 64'(4'b0110));
      chk("t1_flag_reg", 64'(flag_reg), 64'(4'b0110));
      chk("t1_rr", 64'(dbg_rr), 64'(1));

      // SUB with borrow, flags not written
      req_q[1].push_back('{a: 32'd5, b: 32'd7, op: 2'b01, sf: 1'b0});
      wait_drain(200);
      chk("t2_result", 64'(rsp_result), 64'(32'hFFFF_FFFE));
      chk("t2_flag", 64'(rsp_flag), 64'(4'b1010));
      chk("t2_flag_reg", 64'(flag_reg), 64'(4'b0110));

      // only requester 1 valid while the pointer is at 0
      chk("t6_rr_before", 64'(dbg_rr), 64'(0));
      req_q[1].push_back('{a: 32'h1234_5678, b: 32'h0F0F_0F0F, op: 2'b10, sf: 1'b0});
      wait_drain(200);
      chk("t6_id", 64'(rsp_id), 64'(1));
      chk("t6_rr_after", 64'(dbg_rr), 64'(0));

      // both requesters continuously valid: grants alternate
      dut_ids.delete();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NUM_REQ; i++)
            req_q[i].push_back('{a: 32'h7FFF_FFFF, b: 32'h0000_0001, op: 2'b00, sf: 1'b0});
      wait_drain(300);
      chk("t3_count", 64'(dut_ids.size()), 64'(4));
      for (int k = 0; k < dut_ids.size() && k < 4; k++)
         chk("t3_grant_order", 64'(dut_ids[k]), 64'(k % 2));
      chk("t3_result", 64'(rsp_result), 64'(32'h8000_0000));
      chk("t3_flag", 64'(rsp_flag), 64'(4'b1001));

      // response back-pressure for 5 cycles, next request waiting behind it
      rdy_mode = 2;
      req_q[0].push_back('{a: 32'hF0F0_0000, b: 32'h0000_000F, op: 2'b11, sf: 1'b0});
      req_q[1].push_back('{a: 32'd1, b: 32'd2, op: 2'b00, sf: 1'b0});
      wait_phase(2, "t4_resp_timeout");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #3;
         chk("t4_hold_valid", 64'(rsp_valid), 64'(1));
         chk("t4_hold_result", 64'(rsp_result), 64'(32'hF0F0_000F));
         chk("t4_hold_ready", 64'(req_ready), 64'(0));
      end
      wait_drain(300);
      rdy_mode = 0;

      // reset in the middle of EXEC discards the operation
      req_q[0].push_back('{a: 32'hFFFF_0000, b: 32'h00FF_00FF, op: 2'b10, sf: 1'b1});
      wait_phase(1, "t5_exec_timeout");
      rst = 1'b1;
      #1;
      chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t5_flag_reg", 64'(flag_reg), 64'(0));
      chk("t5_state", 64'(dbg_state), 64'(0));
      chk("t5_rr", 64'(dbg_rr), 64'(0));
      for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
      @(negedge clk);
      #2;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #3;
      chk("t5_no_response", 64'(rsp_valid), 64'(0));

      // random traffic with random back-pressure and request gaps
      rdy_mode = 1;
      gaps     = 1'b1;
      for (int k = 0; k < 60; k++)
         for (int i = 0; i < NUM_REQ; i++)
            req_q[i].push_back('{a: rand_word(), b: rand_word(),
                                 op: 2'($urandom_range(0, 3)), sf: 1'($urandom_range(0, 1))});
      wait_drain(8000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
